mem_responder: RTL and testbench

//   Memory-bus target answering the 6502 core's read/write cycles.
//   - Decodes the 16-bit address into RAM (0x0000 up), ROM (0xF000-0xFFFF) or unmapped.
//   - Inserts per-region wait states and handshakes completion back to the core with rdy.
//   - Sits between cpu and the RAM/ROM arrays in top. This is the responder end of the
//     bus the core initiates.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/wait_counter.sv | 38 +++
 rtl/mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and address decode for the 6502 memory responder.
// RAM occupies the bottom of the map, ROM the top, everything else is unmapped.
package mem_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_ROM,
        REG_UNM
    } region_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } memst_t;

    // First ROM byte for the default 4 KiB ROM (0x10000 - 2**12).
    localparam logic [16:0] ROM_BASE = 17'h0F000;

    // RAM is tested first so an overlapping configuration resolves to RAM.
    function automatic region_t decode(input logic [15:0] addr,
                                       input logic [16:0] ram_top  = 17'h01000,
                                       input logic [16:0] rom_base = ROM_BASE);
        logic [16:0] a;
        a = {1'b0, addr};
        if (a < ram_top) begin
            return REG_RAM;
        end
        if (a >= rom_base) begin
            return REG_ROM;
        end
        return REG_UNM;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter: loaded with the region wait count on request
// acceptance, decremented once per cycle, and flags the final wait cycle.
module wait_counter #(
    parameter int WAIT_W = 3
) (
    input  logic              ph2,
    input  logic              reset,
    input  logic              load,
    input  logic              dec,
    input  logic [WAIT_W-1:0] load_val,
    output logic              last
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Load wins over decrement; the counter parks at zero once drained.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder for the 6502 core: decodes RAM/ROM/unmapped, inserts
// per-region wait states and returns a one-cycle rdy pulse per access.
// Optional feature macro: MEM_ROM_WRITE_EN (when defined, bus writes to ROM
// commit like RAM writes instead of being dropped and raising bus_err).
module mem_responder
    import mem_pkg::*;
#(
    parameter int RAM_AW   = 12,
    parameter int ROM_AW   = 12,
    parameter int WAIT_W   = 3,
    parameter int RAM_WAIT = 0,
    parameter int ROM_WAIT = 1,
    parameter int UNM_WAIT = 0
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic        valid,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdy,
    output logic        bus_err
);

    localparam int          IDX_W   = (RAM_AW > ROM_AW) ? RAM_AW : ROM_AW;
    localparam logic [16:0] RAM_TOP = 17'd1 << RAM_AW;
    localparam logic [16:0] ROM_LO  = 17'h10000 - (17'd1 << ROM_AW);

    // Arrays keep these names so benches can preload them hierarchically.
    logic [7:0] RAM [2**RAM_AW];
    logic [7:0] ROM [2**ROM_AW];

    memst_t            state_q,   state_d;
    logic [IDX_W-1:0]  addr_q,    addr_d;
    logic              rw_q,      rw_d;
    logic [7:0]        wdata_q,   wdata_d;
    region_t           region_q,  region_d;
    logic [7:0]        rdata_q,   rdata_d;
    logic              rdy_q,     rdy_d;
    logic              bus_err_q, bus_err_d;

    region_t           in_region;
    logic [WAIT_W-1:0] in_wait;
    region_t           acc_region;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_rw;
    logic [7:0]        acc_wdata;
    logic [RAM_AW-1:0] ram_idx;
    logic [ROM_AW-1:0] rom_idx;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_last;
    logic              enter_resp;
    logic              ram_we;
    logic              rom_we;
    logic              rom_wr_bad;

    function automatic logic [WAIT_W-1:0] region_wait(input region_t r);
        case (r)
            REG_RAM: return WAIT_W'(RAM_WAIT);
            REG_ROM: return WAIT_W'(ROM_WAIT);
            default: return WAIT_W'(UNM_WAIT);
        endcase
    endfunction

    wait_counter #(
        .WAIT_W   (WAIT_W)
    ) u_wait (
        .ph2      (ph2),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (in_wait),
        .last     (cnt_last)
    );

    // The access that completes this edge: live bus fields when a zero-wait
    // request is accepted straight from IDLE, otherwise the latched request.
    always_comb begin
        in_region  = decode(addr, RAM_TOP, ROM_LO);
        in_wait    = region_wait(in_region);
        acc_region = (state_q == IDLE) ? in_region        : region_q;
        acc_idx    = (state_q == IDLE) ? addr[IDX_W-1:0]  : addr_q;
        acc_rw     = (state_q == IDLE) ? rw               : rw_q;
        acc_wdata  = (state_q == IDLE) ? wdata            : wdata_q;
        ram_idx    = acc_idx[RAM_AW-1:0];
        rom_idx    = acc_idx[ROM_AW-1:0];
    end

    // Next-state, request latch and registered-output computation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        region_d   = region_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    addr_d   = addr[IDX_W-1:0];
                    rw_d     = rw;
                    wdata_d  = wdata;
                    region_d = in_region;
                    if (in_wait == '0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d  = WAIT;
                        cnt_load = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef MEM_ROM_WRITE_EN
        rom_we     = enter_resp && (acc_region == REG_ROM) && !acc_rw;
        rom_wr_bad = 1'b0;
`else
        rom_we     = 1'b0;
        rom_wr_bad = (acc_region == REG_ROM) && !acc_rw;
`endif
        ram_we = enter_resp && (acc_region == REG_RAM) && !acc_rw;

        rdy_d   = enter_resp;
        rdata_d = rdata_q;
        if (enter_resp && acc_rw) begin
            case (acc_region)
                REG_RAM: rdata_d = RAM[ram_idx];
                REG_ROM: rdata_d = ROM[rom_idx];
                default: rdata_d = 8'hFF;
            endcase
        end
        bus_err_d = bus_err_q |
                    (enter_resp && ((acc_region == REG_UNM) || rom_wr_bad));
    end

    // FSM and output registers; reset abandons any in-flight access.
    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b1;
            wdata_q   <= 8'h00;
            region_q  <= REG_RAM;
            rdata_q   <= 8'h00;
            rdy_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            region_q  <= region_d;
            rdata_q   <= rdata_d;
            rdy_q     <= rdy_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Array writes commit on the edge that enters RESP; contents survive reset.
    always_ff @(posedge ph2) begin
        if (ram_we) begin
            RAM[ram_idx] <= acc_wdata;
        end
        if (rom_we) begin
            ROM[rom_idx] <= acc_wdata;
        end
    end

    assign rdata   = rdata_q;
    assign rdy     = rdy_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a default-configured instance plus a
// long-wait instance (RAM/ROM wait 3) used for the reset-during-wait scenario.
module tb_mem_responder;
    import mem_pkg::*;

    typedef struct {
        logic [7:0] rdata;
        int         lat;
        string      tag;
    } exp_t;

    logic        ph2;
    logic        reset;
    logic        valid_a;
    logic        valid_b;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata_a;
    logic [7:0]  rdata_b;
    logic        rdy_a;
    logic        rdy_b;
    logic        err_a;
    logic        err_b;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    mem_responder dut (
        .ph2     (ph2),
        .reset   (reset),
        .valid   (valid_a),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata_a),
        .rdy     (rdy_a),
        .bus_err (err_a)
    );

    mem_responder #(
        .RAM_WAIT (3),
        .ROM_WAIT (3)
    ) dut_w (
        .ph2     (ph2),
        .reset   (reset),
        .valid   (valid_b),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata_b),
        .rdy     (rdy_b),
        .bus_err (err_b)
    );

    initial ph2 = 1'b0;
    always #5 ph2 = ~ph2;

    // Drive one request and wait (bounded) for rdy; lat counts cycles after
    // the accepting edge, so lat==1 means rdy in cycle k+1.
    task automatic issue(input bit sel_b, input logic r, input logic [15:0] a,
                         input logic [7:0] d, output logic [7:0] od, output int lat);
        @(negedge ph2);
        rw    = r;
        addr  = a;
        wdata = d;
        if (sel_b) valid_b = 1'b1;
        else       valid_a = 1'b1;
        lat = 0;
        od  = 8'h00;
        while (lat < 20) begin
            @(negedge ph2);
            lat++;
            if (sel_b ? rdy_b : rdy_a) begin
                od = sel_b ? rdata_b : rdata_a;
                break;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge ph2);
        n_checks++;
        if (rdy_a !== 1'b0 || rdata_a !== 8'h00 || err_a !== 1'b0)
            $display("[TB] FAIL reset_a: got rdy=%b rdata=%h err=%b expected rdy=0 rdata=00 err=0",
                     rdy_a, rdata_a, err_a);
        else n_pass++;
        n_checks++;
        if (rdy_b !== 1'b0 || rdata_b !== 8'h00 || err_b !== 1'b0)
            $display("[TB] FAIL reset_b: got rdy=%b rdata=%h err=%b expected rdy=0 rdata=00 err=0",
                     rdy_b, rdata_b, err_b);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_reset_vector();
        exp_t e; logic [7:0] od; int lat;
        sb.push_back('{8'h00, 2, "vec_lo"});
        issue(1'b0, 1'b1, 16'hFFFC, 8'h00, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
        sb.push_back('{8'hF0, 2, "vec_hi"});
        issue(1'b0, 1'b1, 16'hFFFD, 8'h00, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
    endtask

    task automatic test_ram();
        exp_t e; logic [7:0] od; int lat;
        sb.push_back('{8'hF0, 1, "ram_wr"});
        issue(1'b0, 1'b0, 16'h0003, 8'h22, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
        n_checks++;
        if (dut.RAM[3] !== 8'h22)
            $display("[TB] FAIL ram_cell: got %h expected 22", dut.RAM[3]);
        else n_pass++;
        sb.push_back('{8'h22, 1, "ram_rd"});
        issue(1'b0, 1'b1, 16'h0003, 8'h00, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
        n_checks++;
        if (err_a !== 1'b0)
            $display("[TB] FAIL ram_err: got %b expected 0", err_a);
        else n_pass++;
    endtask

    task automatic test_rom_write();
        exp_t e; logic [7:0] od; int lat;
        sb.push_back('{8'h22, 2, "rom_wr"});
        issue(1'b0, 1'b0, 16'hF010, 8'h55, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
`ifdef MEM_ROM_WRITE_EN
        sb.push_back('{8'h55, 2, "rom_readback"});
        issue(1'b0, 1'b1, 16'hF010, 8'h00, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
        n_checks++;
        if (err_a !== 1'b0)
            $display("[TB] FAIL rom_wr_err: got %b expected 0", err_a);
        else n_pass++;
`else
        n_checks++;
        if (dut.ROM[16] !== 8'hA5)
            $display("[TB] FAIL rom_cell: got %h expected a5", dut.ROM[16]);
        else n_pass++;
        n_checks++;
        if (err_a !== 1'b1)
            $display("[TB] FAIL rom_wr_err: got %b expected 1", err_a);
        else n_pass++;
`endif
    endtask

    task automatic test_unmapped();
        exp_t e; logic [7:0] od; int lat;
        sb.push_back('{8'hFF, 1, "unm_rd"});
        issue(1'b0, 1'b1, 16'h8000, 8'h00, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
        n_checks++;
        if (err_a !== 1'b1)
            $display("[TB] FAIL unm_err: got %b expected 1", err_a);
        else n_pass++;
        sb.push_back('{8'h22, 1, "after_unm"});
        issue(1'b0, 1'b1, 16'h0003, 8'h00, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        exp_t e; logic [7:0] od; int lat;
        sb.push_back('{8'h00, 4, "w_wr11"});
        issue(1'b1, 1'b0, 16'h0005, 8'h11, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
        sb.push_back('{8'h11, 4, "w_rd11"});
        issue(1'b1, 1'b1, 16'h0005, 8'h00, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
        @(negedge ph2);
        rw      = 1'b0;
        addr    = 16'h0005;
        wdata   = 8'h77;
        valid_b = 1'b1;
        @(posedge ph2);
        @(posedge ph2);
        #1;
        reset   = 1'b1;
        valid_b = 1'b0;
        @(negedge ph2);
        n_checks++;
        if (rdy_b !== 1'b0 || rdata_b !== 8'h00)
            $display("[TB] FAIL wait_reset_out: got rdy=%b rdata=%h expected rdy=0 rdata=00", rdy_b, rdata_b);
        else n_pass++;
        n_checks++;
        if (dut_w.state_q !== IDLE)
            $display("[TB] FAIL wait_reset_state: got %0d expected %0d", dut_w.state_q, IDLE);
        else n_pass++;
        reset = 1'b0;
        sb.push_back('{8'h11, 4, "w_after_rst"});
        issue(1'b1, 1'b1, 16'h0005, 8'h00, od, lat);
        e = sb.pop_front();
        n_checks++;
        if (od !== e.rdata || lat != e.lat)
            $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [7:0] od; int lat; int got; int last_cyc; logic prev;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{8'h00, 1, "b2b_wr"});
            issue(1'b0, 1'b0, 16'h0010 + 16'(i), 8'hA0 + 8'(i), od, lat);
            e = sb.pop_front();
            n_checks++;
            if (od !== e.rdata || lat != e.lat)
                $display("[TB] FAIL %s: got rdata=%h lat=%0d expected rdata=%h lat=%0d", e.tag, od, lat, e.rdata, e.lat);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) sb.push_back('{8'hA0 + 8'(i), 0, "b2b_rd"});
        @(negedge ph2);
        rw      = 1'b1;
        addr    = 16'h0010;
        valid_a = 1'b1;
        got      = 0;
        last_cyc = 0;
        prev     = 1'b0;
        for (int c = 1; c <= 20 && got < 4; c++) begin
            @(negedge ph2);
            if (rdy_a) begin
                n_checks++;
                if (prev)
                    $display("[TB] FAIL b2b_consecutive: got rdy in cycle %0d and %0d expected gap", c - 1, c);
                else n_pass++;
                e = sb.pop_front();
                n_checks++;
                if (rdata_a !== e.rdata)
                    $display("[TB] FAIL %s: got %h expected %h", e.tag, rdata_a, e.rdata);
                else n_pass++;
                got++;
                last_cyc = c;
                addr = 16'h0010 + 16'(got);
            end
            prev = rdy_a;
        end
        valid_a = 1'b0;
        n_checks++;
        if (got != 4 || last_cyc != 7)
            $display("[TB] FAIL b2b_rate: got %0d pulses last cycle %0d expected 4 pulses last cycle 7", got, last_cyc);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        rw       = 1'b1;
        addr     = 16'h0000;
        wdata    = 8'h00;
        dut.ROM[4092] <= 8'h00;
        dut.ROM[4093] <= 8'hF0;
        dut.ROM[16]   <= 8'hA5;
        repeat (2) @(posedge ph2);
        test_reset();
        test_reset_vector();
        test_ram();
        test_rom_write();
        test_unmapped();
        test_reset_in_wait();
        test_back_to_back();
        repeat (2) @(negedge ph2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
